// File: rtl/udp_ts_buf_pkg.sv
// ---------------------------------------------------------------------------
// udp_ts_buf_pkg
// Shared definitions for the UDP/TS free-buffer pointer pool:
//   - state_e           : pool controller FSM states (3-bit encoding)
//   - clog2()           : ceiling log2 for parameter arithmetic
//   - pointer_width_ok(): elaboration-time consistency check of the pool
//                         geometry (pointer width must equal clog2(pointers))
// ---------------------------------------------------------------------------
package udp_ts_buf_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_POP_RD   = 3'd2,
    ST_POP_DATA = 3'd3,
    ST_PUSH     = 3'd4
  } state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // A pool is well formed when it holds a power-of-two number (>= 4) of
  // pointers and the pointer width addresses exactly that many entries.
  function automatic bit pointer_width_ok(input int pointers, input int width);
    return (pointers >= 4) && (width == clog2(pointers)) && ((1 << width) == pointers);
  endfunction

endpackage

// File: rtl/udp_ts_rr_arbiter.sv
// ---------------------------------------------------------------------------
// udp_ts_rr_arbiter
// Round-robin arbiter over P_CHANNELS requesters. The search for the next
// grant starts at the channel after the last accepted grant, so a channel
// that keeps requesting cannot starve its neighbours.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   req        : per-channel request vector
//   accept     : the current grant was taken; advance the round-robin pointer
//   grant      : one-hot grant (all zero when nothing requests)
// ---------------------------------------------------------------------------
module udp_ts_rr_arbiter
  import udp_ts_buf_pkg::*;
#(
  parameter int P_CHANNELS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [P_CHANNELS-1:0] req,
  input  logic                  accept,
  output logic [P_CHANNELS-1:0] grant
);

  localparam int IW = (P_CHANNELS > 1) ? clog2(P_CHANNELS) : 1;

  logic [IW-1:0] last_q;
  logic [IW-1:0] grant_idx;
  logic          found;
  int            idx;

  // NOTE: every variable driven in a combinational block gets a default
  // before any condition, so no path leaves it holding a value (no latch).
  always_comb begin
    grant     = '0;
    grant_idx = last_q;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= P_CHANNELS; off++) begin
      idx = int'(last_q) + off;
      if (idx >= P_CHANNELS) idx = idx - P_CHANNELS;
      if (!found && req[IW'(idx)]) begin
        found     = 1'b1;
        grant_idx = IW'(idx);
      end
    end
    if (found) grant = P_CHANNELS'(1) << grant_idx;
  end

  // NOTE: registers are updated with non-blocking assignments so every
  // flop samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Pointing at the last channel makes channel 0 first after reset.
      last_q <= IW'(P_CHANNELS - 1);
    end else if (accept && found) begin
      last_q <= grant_idx;
    end
  end

endmodule

// File: rtl/udp_ts_buf_pool_ctrl.sv
// ---------------------------------------------------------------------------
// udp_ts_buf_pool_ctrl
// Free-buffer pointer pool for the UDP/TS receive path. Free pointers live
// as a LIFO stack in a single-port RAM with registered read; free_count is
// the stack depth. P_CHANNELS fetch requesters share the pool through a
// round-robin arbiter; one release port returns pointers from the TX side.
// Fetch and release alternate when both are pending.
//
// Ports:
//   payload_clk, payload_rst_n : clock, synchronous active-low reset
//   fetch_req / fetch_ack      : per-channel held request, one-hot 1-cycle ack
//   fetch_empty                : with ack, pool was empty (pointer_out = 0)
//   pointer_out                : fetched pointer, holds between fetches
//   release_req / release_ack  : held release request, 1-cycle ack
//   release_pointer            : pointer being returned
//   release_err                : with ack, pointer was dropped
//   free_count                 : free pointers, 0..P_POINTERS
//   low_water                  : registered free_count <= P_LOW_WATERMARK
//   overflow_flag              : sticky low-water / empty-fetch indication
//   clear_overflow             : clears overflow_flag (wins over set)
//   initialised                : high once the stack has been filled
//
// Build option: define UDP_TS_BUF_DOUBLE_FREE_CHECK_EN to track allocated
// pointers and drop (with release_err) releases of pointers not handed out.
// ---------------------------------------------------------------------------
module udp_ts_buf_pool_ctrl
  import udp_ts_buf_pkg::*;
#(
  parameter int P_POINTERS      = 16,
  parameter int P_POINTER_WIDTH = 4,
  parameter int P_CHANNELS      = 2,
  parameter int P_LOW_WATERMARK = 2
) (
  input  logic                       payload_clk,
  input  logic                       payload_rst_n,
  input  logic [P_CHANNELS-1:0]      fetch_req,
  output logic [P_CHANNELS-1:0]      fetch_ack,
  output logic                       fetch_empty,
  output logic [P_POINTER_WIDTH-1:0] pointer_out,
  input  logic                       release_req,
  input  logic [P_POINTER_WIDTH-1:0] release_pointer,
  output logic                       release_ack,
  output logic                       release_err,
  output logic [P_POINTER_WIDTH:0]   free_count,
  output logic                       low_water,
  output logic                       overflow_flag,
  input  logic                       clear_overflow,
  output logic                       initialised
);

  localparam int             W          = P_POINTER_WIDTH;
  localparam logic [W:0]     FULL_COUNT = (W+1)'(P_POINTERS);
  localparam logic [W:0]     LOW_MARK   = (W+1)'(P_LOW_WATERMARK);
  localparam logic [W-1:0]   LAST_ADDR  = W'(P_POINTERS - 1);

  if (!pointer_width_ok(P_POINTERS, P_POINTER_WIDTH)) begin : g_bad_geometry
    $error("udp_ts_buf_pool_ctrl: P_POINTER_WIDTH must equal clog2(P_POINTERS), P_POINTERS >= 4");
  end
  if (P_CHANNELS < 1 || P_CHANNELS > 8) begin : g_bad_channels
    $error("udp_ts_buf_pool_ctrl: P_CHANNELS must be 1..8");
  end

  state_e                state_q, state_d;
  logic [W-1:0]          init_addr_q, init_addr_d;
  logic [P_CHANNELS-1:0] ch_q, ch_d;
  logic [W-1:0]          rel_ptr_q, rel_ptr_d;
  logic                  last_fetch_q, last_fetch_d;

  logic [P_CHANNELS-1:0] fetch_ack_d;
  logic                  fetch_empty_d;
  logic [W-1:0]          pointer_out_d;
  logic                  release_ack_d, release_err_d;
  logic [W:0]            free_count_d;
  logic                  initialised_d;

  logic [W-1:0]          ram [P_POINTERS];
  logic                  ram_we;
  logic [W-1:0]          ram_addr, ram_wdata, ram_rdata;

  logic [P_CHANNELS-1:0] arb_grant;
  logic                  arb_accept;
  logic                  acking, take_fetch, take_release;
  logic                  pool_full, push_ok;

  udp_ts_rr_arbiter #(.P_CHANNELS(P_CHANNELS)) u_arbiter (
    .clk    (payload_clk),
    .rst_n  (payload_rst_n),
    .req    (fetch_req),
    .accept (arb_accept),
    .grant  (arb_grant)
  );

  // Requests are not sampled while an ack is showing: the requester still
  // holds its request in that cycle and must not be served twice.
  assign acking       = (|fetch_ack) | release_ack;
  assign take_fetch   = (|fetch_req) && (!release_req || !last_fetch_q);
  assign take_release = release_req && !take_fetch;
  assign pool_full    = (free_count == FULL_COUNT);

`ifdef UDP_TS_BUF_DOUBLE_FREE_CHECK_EN
  logic [P_POINTERS-1:0] alloc_q, alloc_d;

  assign push_ok = !pool_full && alloc_q[rel_ptr_q];

  always_comb begin
    alloc_d = alloc_q;
    if (state_q == ST_POP_DATA)        alloc_d[ram_rdata] = 1'b1;
    if (state_q == ST_PUSH && push_ok) alloc_d[rel_ptr_q] = 1'b0;
  end

  always_ff @(posedge payload_clk) begin
    if (!payload_rst_n) alloc_q <= '0;
    else                alloc_q <= alloc_d;
  end
`else
  assign push_ok = !pool_full;
`endif

  always_comb begin
    state_d       = state_q;
    init_addr_d   = init_addr_q;
    ch_d          = ch_q;
    rel_ptr_d     = rel_ptr_q;
    last_fetch_d  = last_fetch_q;
    fetch_ack_d   = '0;
    fetch_empty_d = 1'b0;
    pointer_out_d = pointer_out;
    release_ack_d = 1'b0;
    release_err_d = 1'b0;
    free_count_d  = free_count;
    initialised_d = initialised;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    arb_accept    = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        ram_we      = 1'b1;
        ram_addr    = init_addr_q;
        ram_wdata   = init_addr_q;
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == LAST_ADDR) begin
          free_count_d  = FULL_COUNT;
          initialised_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (!acking) begin
          if (take_fetch) begin
            arb_accept   = 1'b1;
            ch_d         = arb_grant;
            last_fetch_d = 1'b1;
            if (free_count == '0) begin
              // Empty pool: answer immediately, no RAM access.
              fetch_ack_d   = arb_grant;
              fetch_empty_d = 1'b1;
              pointer_out_d = '0;
            end else begin
              state_d = ST_POP_RD;
            end
          end else if (take_release) begin
            last_fetch_d = 1'b0;
            rel_ptr_d    = release_pointer;
            state_d      = ST_PUSH;
          end
        end
      end

      ST_POP_RD: begin
        // Top of stack sits at free_count-1; data returns next cycle.
        ram_addr     = W'(free_count - 1'b1);
        free_count_d = free_count - 1'b1;
        state_d      = ST_POP_DATA;
      end

      ST_POP_DATA: begin
        fetch_ack_d   = ch_q;
        pointer_out_d = ram_rdata;
        state_d       = ST_IDLE;
      end

      ST_PUSH: begin
        release_ack_d = 1'b1;
        state_d       = ST_IDLE;
        if (push_ok) begin
          ram_we       = 1'b1;
          ram_addr     = free_count[W-1:0];
          ram_wdata    = rel_ptr_q;
          free_count_d = free_count + 1'b1;
        end else begin
          release_err_d = 1'b1;
        end
      end

      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge payload_clk) begin
    if (!payload_rst_n) begin
      state_q       <= ST_INIT;
      init_addr_q   <= '0;
      ch_q          <= '0;
      rel_ptr_q     <= '0;
      last_fetch_q  <= 1'b0;
      fetch_ack     <= '0;
      fetch_empty   <= 1'b0;
      pointer_out   <= '0;
      release_ack   <= 1'b0;
      release_err   <= 1'b0;
      free_count    <= '0;
      low_water     <= 1'b0;
      overflow_flag <= 1'b0;
      initialised   <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_addr_q   <= init_addr_d;
      ch_q          <= ch_d;
      rel_ptr_q     <= rel_ptr_d;
      last_fetch_q  <= last_fetch_d;
      fetch_ack     <= fetch_ack_d;
      fetch_empty   <= fetch_empty_d;
      pointer_out   <= pointer_out_d;
      release_ack   <= release_ack_d;
      release_err   <= release_err_d;
      free_count    <= free_count_d;
      initialised   <= initialised_d;
      // Gated by initialised so the empty count during INIT is not reported.
      low_water     <= initialised && (free_count <= LOW_MARK);
      overflow_flag <= clear_overflow ? 1'b0 : (overflow_flag | low_water | fetch_empty);
    end
  end

  // NOTE: the pointer RAM has no reset; INIT writes every entry before the
  // stack can be read, so clearing it would only cost logic.
  always_ff @(posedge payload_clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

endmodule

// File: tb/tb_udp_ts_buf_pool_ctrl.sv
// ---------------------------------------------------------------------------
// tb_udp_ts_buf_pool_ctrl
// Self-checking bench for udp_ts_buf_pool_ctrl (default 16 pointers,
// 2 channels, low watermark 2). Directed transaction table, hand-written
// watermark/empty/full/arbitration sequences, then randomized traffic
// checked against a LIFO stack model. Honours
// UDP_TS_BUF_DOUBLE_FREE_CHECK_EN when the design is built with it.
// ---------------------------------------------------------------------------
module tb_udp_ts_buf_pool_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] fetch_req;
  logic [1:0] fetch_ack;
  logic       fetch_empty;
  logic [3:0] pointer_out;
  logic       release_req;
  logic [3:0] release_pointer;
  logic       release_ack;
  logic       release_err;
  logic [4:0] free_count;
  logic       low_water;
  logic       overflow_flag;
  logic       clear_overflow;
  logic       initialised;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  udp_ts_buf_pool_ctrl #(
    .P_POINTERS(16), .P_POINTER_WIDTH(4), .P_CHANNELS(2), .P_LOW_WATERMARK(2)
  ) dut (
    .payload_clk     (clk),
    .payload_rst_n   (rst_n),
    .fetch_req       (fetch_req),
    .fetch_ack       (fetch_ack),
    .fetch_empty     (fetch_empty),
    .pointer_out     (pointer_out),
    .release_req     (release_req),
    .release_pointer (release_pointer),
    .release_ack     (release_ack),
    .release_err     (release_err),
    .free_count      (free_count),
    .low_water       (low_water),
    .overflow_flag   (overflow_flag),
    .clear_overflow  (clear_overflow),
    .initialised     (initialised)
  );

  typedef struct {
    bit is_fetch;
    int ch;
    int rel_ptr;
    int exp_lat;
    int exp_ack;
    int exp_empty;
    int exp_ptr;
    int exp_err;
    int exp_count;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    check_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic vec_t mk_fetch(input int ch, input int lat, input int ptr,
                                    input int empty, input int cnt);
    vec_t v;
    v.is_fetch = 1'b1; v.ch = ch; v.rel_ptr = 0; v.exp_lat = lat;
    v.exp_ack = 1 << ch; v.exp_empty = empty; v.exp_ptr = ptr;
    v.exp_err = 0; v.exp_count = cnt;
    return v;
  endfunction

  function automatic vec_t mk_rel(input int ptr, input int err, input int cnt);
    vec_t v;
    v.is_fetch = 1'b0; v.ch = 0; v.rel_ptr = ptr; v.exp_lat = 2;
    v.exp_ack = 0; v.exp_empty = 0; v.exp_ptr = 0;
    v.exp_err = err; v.exp_count = cnt;
    return v;
  endfunction

  // One isolated transaction: raise in an idle cycle, wait for its ack,
  // drop the request in the ack cycle, then compare everything.
  task automatic do_txn(input vec_t v, input string tag);
    int  lat;
    bit  seen;
    @(negedge clk);
    if (v.is_fetch) begin
      fetch_req = 2'(1 << v.ch);
    end else begin
      release_req     = 1'b1;
      release_pointer = 4'(v.rel_ptr);
    end
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      lat++;
      seen = (fetch_ack != 2'b00) || release_ack;
    end
    fetch_req   = 2'b00;
    release_req = 1'b0;
    check({tag, " ack seen"}, int'(seen), 1);
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " free_count"}, int'(free_count), v.exp_count);
    if (v.is_fetch) begin
      check({tag, " fetch_ack"}, int'(fetch_ack), v.exp_ack);
      check({tag, " fetch_empty"}, int'(fetch_empty), v.exp_empty);
      check({tag, " pointer_out"}, int'(pointer_out), v.exp_ptr);
      check({tag, " low_water"}, int'(low_water), int'(v.exp_count <= 2));
    end else begin
      check({tag, " release_ack"}, int'(release_ack), 1);
      check({tag, " release_err"}, int'(release_err), v.exp_err);
    end
  endtask

  task automatic reset_and_init(input string tag);
    logic [16:0] outs;
    int n;
    rst_n = 1'b0; fetch_req = 2'b00; release_req = 1'b0;
    release_pointer = 4'd0; clear_overflow = 1'b0;
    repeat (3) @(negedge clk);
    outs = {fetch_ack, fetch_empty, pointer_out, release_ack, release_err,
            free_count, low_water, overflow_flag, initialised};
    check({tag, " outputs in reset"}, int'(outs), 0);
    rst_n = 1'b1;
    n = 0;
    while (!initialised && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " init cycles"}, n, 16);
    check({tag, " free_count after init"}, int'(free_count), 16);
    check({tag, " low_water after init"}, int'(low_water), 0);
    check({tag, " overflow after init"}, int'(overflow_flag), 0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
  endtask

  function automatic logic [3:0] pick_ptr(input bit alloc[16]);
    int start;
    start = $urandom_range(0, 15);
`ifdef UDP_TS_BUF_DOUBLE_FREE_CHECK_EN
    if ($urandom_range(0, 3) != 0) begin
      for (int k = 0; k < 16; k++) begin
        if (alloc[(start + k) % 16]) return 4'((start + k) % 16);
      end
    end
`else
    if (alloc[0]) start = start + 0;
`endif
    return 4'(start);
  endfunction

  // Randomized traffic against a LIFO model. Requests only change in ack
  // cycles (or while nothing is pending), so the request set seen at an
  // ack is exactly the set the design arbitrated over.
  task automatic random_phase(input int n_txn);
    int  stack[$];
    bit  alloc[16];
    bit  have_last_type, last_was_fetch, have_last_ch;
    int  last_ch, pend_f, pend_r, ch, exp_ch, n, ptr;
    bit  seen, is_f, ok;
    for (int i = 0; i < 16; i++) begin
      stack.push_back(i);
      alloc[i] = 1'b0;
    end
    have_last_type = 1'b0; last_was_fetch = 1'b0;
    have_last_ch = 1'b0; last_ch = 0;
    fetch_req   = 2'($urandom_range(0, 3));
    release_req = 1'($urandom_range(0, 1));
    if (fetch_req == 2'b00) release_req = 1'b1;
    release_pointer = pick_ptr(alloc);
    for (int t = 0; t < n_txn; t++) begin
      n = 0; seen = 1'b0;
      while (!seen && n < 12) begin
        @(negedge clk);
        n++;
        seen = (fetch_ack != 2'b00) || release_ack;
      end
      if (!seen) begin
        check("rand ack timeout", 0, 1);
        break;
      end
      pend_f = int'(fetch_req);
      pend_r = int'(release_req);
      is_f   = (fetch_ack != 2'b00);
      check("rand single ack", int'(fetch_ack != 2'b00) + int'(release_ack), 1);
      check("rand served type pending", is_f ? int'(pend_f != 0) : pend_r, 1);
      if (pend_f != 0 && pend_r != 0 && have_last_type)
        check("rand type alternation", int'(is_f), int'(!last_was_fetch));
      if (is_f) begin
        ch = -1;
        for (int c = 0; c < 2; c++) if (fetch_ack == 2'(1 << c)) ch = c;
        check("rand ch pending", (ch >= 0) ? ((pend_f >> ch) & 1) : 0, 1);
        if (have_last_ch) begin
          exp_ch = -1;
          for (int k = 1; k <= 2; k++) begin
            int c2;
            c2 = (last_ch + k) % 2;
            if (exp_ch < 0 && ((pend_f >> c2) & 1) != 0) exp_ch = c2;
          end
          check("rand round robin", ch, exp_ch);
        end
        if (stack.size() == 0) begin
          check("rand fetch_empty", int'(fetch_empty), 1);
          check("rand empty pointer", int'(pointer_out), 0);
        end else begin
          ptr = stack.pop_back();
          alloc[ptr] = 1'b1;
          check("rand fetch_empty", int'(fetch_empty), 0);
          check("rand pointer", int'(pointer_out), ptr);
        end
        check("rand low_water", int'(low_water), int'(stack.size() <= 2));
        have_last_ch = 1'b1; last_ch = ch;
        have_last_type = 1'b1; last_was_fetch = 1'b1;
        if (ch >= 0) fetch_req = fetch_req & ~2'(1 << ch);
      end else begin
        ok = stack.size() < 16;
`ifdef UDP_TS_BUF_DOUBLE_FREE_CHECK_EN
        ok = ok && alloc[release_pointer];
`endif
        if (ok) begin
          stack.push_back(int'(release_pointer));
          alloc[release_pointer] = 1'b0;
        end
        check("rand release_err", int'(release_err), int'(!ok));
        have_last_type = 1'b1; last_was_fetch = 1'b0;
        release_req = 1'b0;
      end
      check("rand free_count", int'(free_count), stack.size());
      // Top up requests while the design is in its ack cycle.
      if ($urandom_range(0, 1) == 1) fetch_req = fetch_req | 2'($urandom_range(0, 3));
      if (!release_req && $urandom_range(0, 2) != 0) begin
        release_req = 1'b1;
        release_pointer = pick_ptr(alloc);
      end
      if (fetch_req == 2'b00 && !release_req) fetch_req = 2'b01;
    end
    fetch_req = 2'b00;
    release_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    vec_t vecs[6];
    int   exp_seq[8] = '{1, 4, 2, 4, 1, 4, 2, 4};
    int   got, n, code;

    vecs[0] = mk_fetch(0, 3, 15, 0, 15);
    vecs[1] = mk_fetch(1, 3, 14, 0, 14);
    vecs[2] = mk_rel(14, 0, 15);
    vecs[3] = mk_fetch(1, 3, 14, 0, 14);
    vecs[4] = mk_rel(15, 0, 15);
    vecs[5] = mk_fetch(0, 3, 15, 0, 14);

    reset_and_init("first");

    for (int i = 0; i < 6; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Drain to the watermark: stack now holds 0..13.
    for (int p = 13; p >= 2; p--) do_txn(mk_fetch(0, 3, p, 0, p), $sformatf("drain%0d", p));
    @(negedge clk);
    check("overflow set by low_water", int'(overflow_flag), 1);
    pulse_clear();
    repeat (2) @(negedge clk);
    check("overflow re-set while low", int'(overflow_flag), 1);
    do_txn(mk_rel(2, 0, 3), "release to 3");
    repeat (2) @(negedge clk);
    check("low_water off at 3", int'(low_water), 0);
    pulse_clear();
    repeat (2) @(negedge clk);
    check("overflow cleared", int'(overflow_flag), 0);

    // Empty the pool, then fetch from empty.
    do_txn(mk_fetch(1, 3, 2, 0, 2), "empty a");
    do_txn(mk_fetch(0, 3, 1, 0, 1), "empty b");
    do_txn(mk_fetch(1, 3, 0, 0, 0), "empty c");
    do_txn(mk_fetch(1, 1, 0, 1, 0), "fetch from empty");
    @(negedge clk);
    check("fetch_empty after ack", int'(fetch_empty), 0);
    check("overflow after empty", int'(overflow_flag), 1);

    // Refill, then release into a full pool.
    for (int p = 0; p < 16; p++) do_txn(mk_rel(p, 0, p + 1), $sformatf("refill%0d", p));
    do_txn(mk_rel(5, 1, 16), "release when full");

    // Everyone requests continuously.
    @(negedge clk);
    fetch_req = 2'b11; release_req = 1'b1; release_pointer = 4'd5;
    got = 0; n = 0;
    while (got < 8 && n < 80) begin
      @(negedge clk);
      n++;
      if (fetch_ack != 2'b00 || release_ack) begin
        code = release_ack ? 4 : int'(fetch_ack);
        check($sformatf("arb order %0d", got), code, exp_seq[got]);
        got++;
      end
    end
    fetch_req = 2'b00; release_req = 1'b0;
    check("arb ack count", got, 8);
    repeat (4) @(negedge clk);

    reset_and_init("second");
    random_phase(300);

`ifdef UDP_TS_BUF_DOUBLE_FREE_CHECK_EN
    reset_and_init("dfc");
    do_txn(mk_fetch(0, 3, 15, 0, 15), "dfc fetch");
    do_txn(mk_rel(15, 0, 16), "dfc first release");
    do_txn(mk_rel(15, 1, 16), "dfc double release");
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, check_cnt);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/udp_ts_buf_pool_ctrl.md
Name: udp_ts_buf_pool_ctrl

Overview:
Parametrised free-buffer pointer pool for the UDP/TS receive path. It serves P_CHANNELS independent fetch requesters through a round-robin arbiter and one release port from the TX side. Free pointers are kept as a LIFO stack in a single-port RAM with registered read. It reports free count, a low-watermark flag, a sticky overflow flag, and explicit empty/full errors.

Parameters:
P_POINTERS, 16, number of buffer pointers (power of 2, >=4)
P_POINTER_WIDTH, 4, pointer width; must equal clog2(P_POINTERS)
P_CHANNELS, 2, number of fetch requesters (1..8)
P_LOW_WATERMARK, 2, low_water asserted when free_count <= this value

Ports:
payload_clk  in  1  clock
payload_rst_n  in  1  synchronous reset, active low
fetch_req  in  P_CHANNELS  per-channel fetch request; held until matching ack
fetch_ack  out  P_CHANNELS  one-hot, 1-cycle ack; validates pointer_out/fetch_empty
fetch_empty  out  1  with ack: pool was empty, pointer_out invalid (0)
pointer_out  out  P_POINTER_WIDTH  fetched pointer
release_req  in  1  release request; held until release_ack
release_pointer  in  P_POINTER_WIDTH  pointer being returned
release_ack  out  1  1-cycle ack
release_err  out  1  with release_ack: pool was full, pointer dropped
free_count  out  P_POINTER_WIDTH+1  current free pointers, 0..P_POINTERS
low_water  out  1  registered, free_count <= P_LOW_WATERMARK
overflow_flag  out  1  sticky low_water/empty indication
clear_overflow  in  1  clears overflow_flag
initialised  out  1  high once init complete

Behaviour:
- Reset (payload_rst_n=0 at a clock edge): all outputs 0, FSM -> INIT, init address 0; any in-flight transaction is abandoned without ack.
- INIT: one RAM write per cycle, ram[i]=i for i=0..P_POINTERS-1. After the last write: free_count=P_POINTERS, initialised=1, go to IDLE. Requests are ignored during INIT.
- States: INIT, IDLE, POP_RD, POP_DATA, PUSH.
- IDLE samples requests only when no ack output is high in that cycle. This prevents a held request from being re-served in the ack cycle.
- Arbitration when both pending: fetch and release alternate; the last-served type loses. Among fetch channels, round-robin starts at the channel after the last grant.
- Fetch, granted in IDLE at cycle T:
  - free_count==0: go to IDLE; at T+1 fetch_ack[ch]=1, fetch_empty=1, pointer_out=0, no RAM access.
  - Otherwise: T+1 POP_RD drives address free_count-1. T+2 POP_DATA, RAM data valid, free_count decremented. T+3 fetch_ack[ch]=1 with pointer_out=data, FSM in IDLE.
- Release, granted at T: T+1 PUSH.
  - If free_count<P_POINTERS: write ram[free_count]=release_pointer, increment free_count.
  - Else: no write.
  - In both cases, T+2 release_ack=1, and release_err=1 only if the pool was full.
- pointer_out holds its last value between fetches. fetch_empty and release_err are 0 outside ack cycles.
- low_water is registered from free_count.
- overflow_flag: set on low_water or on any fetch_empty ack; cleared by clear_overflow (clear wins over set in the same cycle).
- A request dropped before its ack is a protocol error. It is still completed and acked; the bench flags it.
- free_count is never below 0 or above P_POINTERS.

Optional Feature:
UDP_TS_BUF_DOUBLE_FREE_CHECK_EN:
- Defined: a P_POINTERS-bit allocated bitmap (all 0 after init) is maintained; the bit is set on a successful fetch and cleared on a successful push. A release of a pointer whose bit is 0 is dropped (no write, count unchanged) and acked with release_err=1.
- Undefined: no bitmap, and release_err flags only the full-pool case.

Decomposition:
- Package udp_ts_buf_pkg holds:
  - state enumeration constants (width 3);
  - clog2 function;
  - the P_POINTER_WIDTH==clog2(P_POINTERS) elaboration check.
- One sub-module, udp_ts_rr_arbiter: parametrised P_CHANNELS round-robin, one-hot grant, advance-on-accept input.
- The RAM is inferred inline.

Test Plan:
- Reset release, P_POINTERS=16 -> initialised=1 after 16 cycles, free_count=16, low_water=0.
- ch0 fetch from full pool -> fetch_ack=2'b01 3 cycles after grant, pointer_out=15, free_count=15; a second fetch returns 14.
- Fetch 14 pointers -> low_water=1 at free_count=2 and overflow_flag set; clear_overflow pulse with low_water still high -> flag stays 1; release to count 3, clear -> 0.
- Empty pool, fetch on ch1 -> fetch_ack=2'b10, fetch_empty=1, pointer_out=0, free_count stays 0; full pool, release 5 -> release_err=1, free_count 16.
- ch0, ch1 and release requested continuously -> grant order alternates fetch/release and ch0/ch1; no channel is served twice consecutively while the other waits.
- With UDP_TS_BUF_DOUBLE_FREE_CHECK_EN: fetch 15, release 15 twice -> first release_err=0, second release_err=1; free_count 16 -> 15 -> 16 -> 16.
